mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) in the NPC core.
- Allows one outstanding transaction at a time and routes each response back to the requester that issued it.
- LSU has default priority. A starvation limiter guarantees IFU progress, and a timeout bounds any stalled memory response.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; mask width is DATA_W/8
- STARVE_LIMIT, 4, consecutive LSU wins over a waiting IFU before IFU is forced to win
- TIMEOUT_CYCLES, 256, cycles in WAIT without a memory response before an error completion

Ports:
- clock in 1: sole clock; all state updates on rising edge
- reset in 1: synchronous, active-low; sampled at rising edge of clock
- if_req_valid in 1: IFU read request
- if_req_ready out 1: IFU request accepted this cycle
- if_req_addr in ADDR_W: IFU address
- if_resp_valid out 1: IFU response pulse
- if_resp_data out DATA_W: IFU read data
- if_resp_err out 1: IFU response is a timeout
- ls_req_valid in 1: LSU request
- ls_req_ready out 1: LSU request accepted this cycle
- ls_req_addr in ADDR_W: LSU address
- ls_req_wen in 1: 1 = write, 0 = read
- ls_req_wdata in DATA_W: write data
- ls_req_mask in DATA_W/8: byte mask; contiguous low bits, e.g. 0x01, 0x03, 0x0F or 0xFF
- ls_resp_valid out 1: LSU response pulse; issued for both reads and writes
- ls_resp_data out DATA_W: LSU read data
- ls_resp_err out 1: LSU response is a timeout
- mem_req_valid out 1: request to memory
- mem_req_ready in 1: memory accepts the request
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_mask out ADDR_W/1/DATA_W/DATA_W/8: registered payload
- mem_resp_valid in 1: memory response
- mem_resp_data in DATA_W: memory read data

Behaviour:
- States are IDLE, ISSUE and WAIT. Registers: owner (IF or LS), starve_cnt, tmo_cnt.
- Reset (reset==0 at an edge):
  - state = IDLE; owner = IF; starve_cnt = 0; tmo_cnt = 0.
  - All mem_req_* registers are 0.
  - Any in-flight transaction is dropped, with no response to either requester.
  - Every output reads 0 while in IDLE with no request valid.
- IDLE, arbitration:
  - req_ready is combinational and is asserted only in IDLE, to the winner only.
  - If only one valid, that requester wins.
  - If both valid: LS wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- On grant:
  - Latch payload into mem_req_*. For IF: wen = 0, wdata = 0, mask = all ones.
  - Set owner; go to ISSUE.
- starve_cnt update:
  - LS grant while if_req_valid = 1: increment, saturating at STARVE_LIMIT.
  - Any IF grant: clear to 0.
  - LS grant while IF is idle: unchanged.
- ISSUE:
  - mem_req_valid = 1 and the payload holds stable until mem_req_ready = 1, then go to WAIT with tmo_cnt = 0.
  - mem_resp_valid in ISSUE is ignored.
- WAIT:
  - On mem_resp_valid: the owner's resp_valid = 1 combinationally in the same cycle, resp_data = mem_resp_data, err = 0; next state IDLE.
  - The non-owner's resp_valid, data and err are 0.
  - Otherwise tmo_cnt increments. When tmo_cnt == TIMEOUT_CYCLES-1 and still no response: owner resp_valid = 1, data = 0, err = 1; go to IDLE.
- mem_resp_valid in IDLE (late response after a timeout) is ignored.
- Latency:
  - Grant at cycle T; mem_req_valid at T+1.
  - With mem_req_ready at T+1 and mem_resp_valid at T+2, the response is at T+2.
  - The next grant is possible at T+3.
- Each accepted request produces exactly one response pulse.
- Requesters must hold valid and payload until ready.

Test Plan:
- IFU-only read 0x8000_0000, memory ready at once, response data 0x1234 one cycle later -> if_req_ready at T, mem_req_valid at T+1, if_resp_valid at T+2 with data 0x1234; ls_resp_valid stays 0.
- Both valid every cycle, memory zero-wait -> grant order LS, LS, LS, LS, IF, LS…; starve_cnt returns to 0 after the IF grant.
- LSU write addr 0x8000_0010, wdata 0xDEAD_BEEF, mask 0x0F; memory holds mem_req_ready low for 3 cycles -> payload stable for all 3 cycles, one ls_resp_valid pulse, if_req_ready stays 0 throughout.
- TIMEOUT_CYCLES = 8, memory never responds to an LSU read -> ls_resp_valid with err = 1 and data 0 after 8 WAIT cycles. A later stray mem_resp_valid in IDLE produces no response.
- reset pulled low for one cycle during WAIT -> next cycle state IDLE, mem_req_valid = 0, no resp_valid on either side. A new IF request is then granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch
// unit (IF) and the load/store unit (LS). Only one transaction is outstanding
// at a time, and each response goes back to the requester that issued it.
// LS has default priority. A starvation counter forces an IF win after
// STARVE_LIMIT consecutive LS wins over a waiting IF. A timeout turns a
// stalled memory response into an error completion.
module mem_port_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clock,
   input  logic                reset,
   // instruction-fetch side
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_resp_data,
   output logic                if_resp_err,
   // load/store side
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic                ls_req_wen,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_mask,
   output logic                ls_resp_valid,
   output logic [DATA_W-1:0]   ls_resp_data,
   output logic                ls_resp_err,
   // memory side
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_mask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data
);

   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_t;

   state_t           state_q, state_d;
   owner_t           owner_q;
   logic [SC_W-1:0]  starve_q;
   logic [TMO_W-1:0] tmo_q;

   logic grant_if;
   logic grant_ls;
   logic resp_fire;
   logic resp_err;
   logic tmo_hit;

   // State register. Reset is synchronous: it only takes effect at a clock edge.
   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge clock) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Arbitration, next-state logic, and the combinational handshake and response outputs.
   // NOTE: every signal gets a default at the top of the block. If a branch
   // left one unassigned, synthesis would infer a latch.
   always_comb begin
      state_d       = state_q;
      grant_if      = 1'b0;
      grant_ls      = 1'b0;
      resp_fire     = 1'b0;
      resp_err      = 1'b0;
      tmo_hit       = 1'b0;
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      if_resp_valid = 1'b0;
      if_resp_data  = '0;
      if_resp_err   = 1'b0;
      ls_resp_valid = 1'b0;
      ls_resp_data  = '0;
      ls_resp_err   = 1'b0;
      mem_req_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // LS wins a tie unless IF has already lost STARVE_LIMIT times in a row
            grant_ls = ls_req_valid && !(if_req_valid && (starve_q == SC_MAX));
            grant_if = if_req_valid && !grant_ls;
            if (grant_ls || grant_if) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tmo_hit = (tmo_q == TMO_LAST);
            if (mem_resp_valid) begin
               resp_fire = 1'b1;
               state_d   = ST_IDLE;
            end else if (tmo_hit) begin
               resp_fire = 1'b1;
               resp_err  = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // While reset is asserted the interface stays quiet, so an in-flight
      // transaction is dropped and no requester sees a false accept.
      if (reset) begin
         if_req_ready  = grant_if;
         ls_req_ready  = grant_ls;
         mem_req_valid = (state_q == ST_ISSUE);
         if (resp_fire) begin
            if (owner_q == OWN_IF) begin
               if_resp_valid = 1'b1;
               if_resp_err   = resp_err;
               if_resp_data  = resp_err ? '0 : mem_resp_data;
            end else begin
               ls_resp_valid = 1'b1;
               ls_resp_err   = resp_err;
               ls_resp_data  = resp_err ? '0 : mem_resp_data;
            end
         end
      end
   end

   // Owner, starvation and timeout counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         owner_q  <= OWN_IF;
         starve_q <= '0;
         tmo_q    <= '0;
      end else begin
         if (grant_ls) begin
            owner_q <= OWN_LS;
            // count only the LS wins that kept a waiting IF out
            if (if_req_valid && (starve_q != SC_MAX)) starve_q <= starve_q + SC_W'(1);
         end else if (grant_if) begin
            owner_q  <= OWN_IF;
            starve_q <= '0;
         end

         if (state_q == ST_ISSUE)                    tmo_q <= '0;
         else if ((state_q == ST_WAIT) && !resp_fire) tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // Registered memory payload. It is loaded on grant, held through ISSUE and
   // WAIT, and cleared when the transaction completes so an idle port reads 0.
   always_ff @(posedge clock) begin
      if (!reset) begin
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_mask  <= '0;
      end else if (grant_ls) begin
         mem_req_addr  <= ls_req_addr;
         mem_req_wen   <= ls_req_wen;
         mem_req_wdata <= ls_req_wdata;
         mem_req_mask  <= ls_req_mask;
      end else if (grant_if) begin
         mem_req_addr  <= if_req_addr;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_mask  <= '1;
      end else if (resp_fire) begin
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_mask  <= '0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Directed scenarios come first,
// then randomized traffic checked against a transaction-level model of the
// arbitration and completion rules. TIMEOUT_CYCLES is shortened to 8.
module tb_mem_port_arbiter;

   localparam int TMO   = 8;
   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_resp_valid;
   logic [63:0] if_resp_data;
   logic        if_resp_err;
   logic        ls_req_valid;
   logic        ls_req_ready;
   logic [63:0] ls_req_addr;
   logic        ls_req_wen;
   logic [63:0] ls_req_wdata;
   logic [7:0]  ls_req_mask;
   logic        ls_resp_valid;
   logic [63:0] ls_resp_data;
   logic        ls_resp_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_mask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;

   int checks    = 0;
   int errors    = 0;
   int if_pulses = 0;
   int ls_pulses = 0;

   mem_port_arbiter #(
      .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
      .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_mask(ls_req_mask),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clock = ~clock;

   // Count response pulses so that "exactly one per request" can be checked.
   always @(negedge clock) begin
      if (if_resp_valid) if_pulses++;
      if (ls_resp_valid) ls_pulses++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // The caller has already driven the requests; the arbiter is in IDLE at posedge+1.
   // This task runs one full transaction: the grant, rdly stalled ISSUE cycles,
   // then a response after rsp_dly WAIT cycles, or a timeout if rsp_dly >= TMO.
   task automatic run_txn(input string tag, input bit win_ls, input logic [63:0] e_addr,
                          input bit e_wen, input logic [63:0] e_wdata, input logic [7:0] e_mask,
                          input int rdly, input int rsp_dly, input logic [63:0] rsp_data);
      bit          fire;
      bit          err;
      logic [63:0] e_data;
      @(negedge clock);
      check({tag, " grant"}, {62'd0, if_req_ready, ls_req_ready}, win_ls ? 64'd1 : 64'd2);
      check({tag, " idle mem_req_valid"}, 64'(mem_req_valid), 64'd0);
      @(posedge clock); #1;
      if (win_ls) ls_req_valid = 1'b0;
      else        if_req_valid = 1'b0;
      for (int k = 0; k <= rdly; k++) begin
         mem_req_ready  = (k == rdly);
         mem_resp_valid = 1'($urandom_range(0, 1));
         mem_resp_data  = {$urandom, $urandom};
         @(negedge clock);
         check({tag, " issue valid"}, 64'(mem_req_valid), 64'd1);
         check({tag, " issue addr"},  mem_req_addr, e_addr);
         check({tag, " issue wen"},   64'(mem_req_wen), 64'(e_wen));
         check({tag, " issue wdata"}, mem_req_wdata, e_wdata);
         check({tag, " issue mask"},  64'(mem_req_mask), 64'(e_mask));
         check({tag, " issue quiet"},
               {60'd0, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid}, 64'd0);
         @(posedge clock); #1;
      end
      mem_req_ready = 1'b0;
      for (int w = 0; w < TMO; w++) begin
         mem_resp_valid = (w == rsp_dly);
         mem_resp_data  = (w == rsp_dly) ? rsp_data : {$urandom, $urandom};
         fire   = (w == rsp_dly) || (w == TMO - 1);
         err    = (w != rsp_dly);
         e_data = err ? 64'd0 : rsp_data;
         @(negedge clock);
         check({tag, " wait flags"},
               {58'd0, if_req_ready, ls_req_ready, if_resp_valid, if_resp_err, ls_resp_valid, ls_resp_err},
               {58'd0, 2'b00, fire && !win_ls, fire && !win_ls && err, fire && win_ls, fire && win_ls && err});
         check({tag, " wait mem_req_valid"}, 64'(mem_req_valid), 64'd0);
         if (fire) begin
            check({tag, " if_resp_data"}, if_resp_data, win_ls ? 64'd0 : e_data);
            check({tag, " ls_resp_data"}, ls_resp_data, win_ls ? e_data : 64'd0);
         end
         @(posedge clock); #1;
         mem_resp_valid = 1'b0;
         if (fire) break;
      end
   endtask

   task automatic new_ls();
      logic [7:0] masks [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};
      ls_req_addr  = {$urandom, $urandom};
      ls_req_wen   = 1'($urandom_range(0, 1));
      ls_req_wdata = {$urandom, $urandom};
      ls_req_mask  = masks[$urandom_range(0, 3)];
   endtask

   initial begin
      bit          order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      bit          if_pend;
      bit          ls_pend;
      bit          exp_ls;
      int          streak;
      int          p_if;
      int          p_ls;
      logic [63:0] rdata;

      // ---- reset state ----
      reset = 1'b0;
      if_req_valid = 1'b0; if_req_addr = '0;
      ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_mask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'hA5A5_5A5A_0F0F_F0F0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      mem_resp_valid = 1'b1;
      @(negedge clock);
      check("reset flags", {56'd0, if_req_ready, if_resp_valid, if_resp_err, ls_req_ready,
                            ls_resp_valid, ls_resp_err, mem_req_valid, mem_req_wen}, 64'd0);
      check("reset mem_req_addr",  mem_req_addr, 64'd0);
      check("reset mem_req_wdata", mem_req_wdata, 64'd0);
      check("reset mem_req_mask",  64'(mem_req_mask), 64'd0);
      check("reset if_resp_data",  if_resp_data, 64'd0);
      check("reset ls_resp_data",  ls_resp_data, 64'd0);
      @(posedge clock); #1;
      mem_resp_valid = 1'b0;

      // ---- IFU-only read, zero-wait memory ----
      p_ls = ls_pulses;
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
      run_txn("if_read", 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'hFF, 0, 0, 64'h1234);
      check("if_read no ls pulse", 64'(ls_pulses - p_ls), 64'd0);

      // ---- both valid every cycle: LS x4, then IF, repeated ----
      if_req_addr = 64'h1000; ls_req_addr = 64'h2000;
      ls_req_wen = 1'b0; ls_req_wdata = 64'h77; ls_req_mask = 8'h03;
      for (int g = 0; g < 10; g++) begin
         if_req_valid = 1'b1; ls_req_valid = 1'b1;
         if (order[g]) run_txn("starve", 1'b1, 64'h2000, 1'b0, 64'h77, 8'h03, 0, 0, 64'(g + 100));
         else          run_txn("starve", 1'b0, 64'h1000, 1'b0, 64'd0, 8'hFF, 0, 0, 64'(g + 100));
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;

      // ---- LSU write with memory stalling for 3 cycles, IF waiting meanwhile ----
      p_ls = ls_pulses;
      if_req_valid = 1'b1; if_req_addr = 64'h3000;
      ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0010; ls_req_wen = 1'b1;
      ls_req_wdata = 64'hDEAD_BEEF; ls_req_mask = 8'h0F;
      run_txn("ls_write", 1'b1, 64'h8000_0010, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3, 0, 64'h0);
      check("ls_write one pulse", 64'(ls_pulses - p_ls), 64'd1);
      run_txn("if_after_write", 1'b0, 64'h3000, 1'b0, 64'd0, 8'hFF, 1, 2, 64'h5555);

      // ---- timeout on an LSU read, then a stray late response ----
      p_if = if_pulses; p_ls = ls_pulses;
      ls_req_valid = 1'b1; ls_req_addr = 64'h4000; ls_req_wen = 1'b0;
      ls_req_wdata = 64'h0; ls_req_mask = 8'hFF;
      run_txn("ls_timeout", 1'b1, 64'h4000, 1'b0, 64'h0, 8'hFF, 0, 1000, 64'h0);
      mem_resp_valid = 1'b1; mem_resp_data = 64'hFEED;
      @(negedge clock);
      check("stray resp quiet", {60'd0, if_resp_valid, ls_resp_valid, if_req_ready, ls_req_ready}, 64'd0);
      @(posedge clock); #1;
      mem_resp_valid = 1'b0;
      check("timeout pulse count", 64'(ls_pulses - p_ls), 64'd1);
      check("timeout no if pulse", 64'(if_pulses - p_if), 64'd0);

      // ---- reset asserted during WAIT ----
      p_if = if_pulses; p_ls = ls_pulses;
      if_req_valid = 1'b1; if_req_addr = 64'h5000;
      @(negedge clock);
      check("rst_wait grant", 64'(if_req_ready), 64'd1);
      @(posedge clock); #1;
      if_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clock);
      check("rst_wait issue", 64'(mem_req_valid), 64'd1);
      @(posedge clock); #1;
      mem_req_ready = 1'b0; reset = 1'b0;
      @(negedge clock);
      check("rst_wait during reset", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
      @(negedge clock);
      check("rst_wait after reset", {60'd0, mem_req_valid, if_resp_valid, ls_resp_valid, if_req_ready}, 64'd0);
      check("rst_wait payload cleared", mem_req_addr, 64'd0);
      @(posedge clock); #1;
      mem_resp_valid = 1'b0;
      repeat (TMO + 2) @(posedge clock);
      #1;
      check("rst_wait no pulses", 64'((if_pulses - p_if) + (ls_pulses - p_ls)), 64'd0);
      if_req_valid = 1'b1; if_req_addr = 64'h6000;
      run_txn("rst_wait new_if", 1'b0, 64'h6000, 1'b0, 64'd0, 8'hFF, 0, 1, 64'hC0DE);

      // ---- randomized traffic against a transaction-level model ----
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      streak = 0; if_pend = 1'b0; ls_pend = 1'b0;
      for (int r = 0; r < 150; r++) begin
         if (!if_pend && $urandom_range(0, 1) == 1) begin
            if_pend = 1'b1; if_req_addr = {$urandom, $urandom};
         end
         if (!ls_pend && $urandom_range(0, 1) == 1) begin
            ls_pend = 1'b1; new_ls();
         end
         if (!if_pend && !ls_pend) begin
            ls_pend = 1'b1; new_ls();
         end
         if_req_valid = if_pend; ls_req_valid = ls_pend;
         exp_ls = (if_pend && ls_pend) ? (streak < LIMIT) : ls_pend;
         rdata = {$urandom, $urandom};
         if (exp_ls)
            run_txn("rand", 1'b1, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_mask,
                    $urandom_range(0, 3), $urandom_range(0, 10), rdata);
         else
            run_txn("rand", 1'b0, if_req_addr, 1'b0, 64'd0, 8'hFF,
                    $urandom_range(0, 3), $urandom_range(0, 10), rdata);
         if (exp_ls) begin
            if (if_pend && streak < LIMIT) streak++;
            ls_pend = 1'b0;
         end else begin
            streak  = 0;
            if_pend = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
